// File: rtl/contador_param_if.sv
// Request/status bundle for contador_param: control strobes toward the counter,
// count value and boundary flags back from it.
interface contador_param_if #(
  parameter int unsigned WIDTH = 8
);
  logic             enable;
  logic             acrescer;
  logic             decrecer;
  logic             carregar;
  logic [WIDTH-1:0] valor_carga;
  logic             limpar;
  logic [WIDTH-1:0] saida;
  logic             no_maximo;
  logic             no_minimo;
  logic             estouro;
  logic             subfluxo;

  modport master (
    output enable, acrescer, decrecer, carregar, valor_carga, limpar,
    input  saida, no_maximo, no_minimo, estouro, subfluxo
  );

  modport slave (
    input  enable, acrescer, decrecer, carregar, valor_carga, limpar,
    output saida, no_maximo, no_minimo, estouro, subfluxo
  );
endinterface

// File: rtl/contador_param.sv
// Parametrised up/down counter with clamp-or-wrap bounds, load, clear, enable,
// optional rising-edge count mode and registered overflow/underflow pulses.
module contador_param #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(8'h6A),
  parameter logic [WIDTH-1:0] MIN_VAL   = '0,
  parameter logic [WIDTH-1:0] MAX_VAL   = {WIDTH{1'b1}},
  parameter logic [WIDTH:0]   STEP      = (WIDTH+1)'(1),
  parameter bit               SATURATE  = 1'b0,
  parameter bit               EDGE_MODE = 1'b0
) (
  input logic             clk,
  input logic             rst_n,
  contador_param_if.slave bus
);

  // All bound arithmetic is done one bit wider than the count.
  localparam logic [WIDTH:0] ONE_X     = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH:0] MIN_X     = {1'b0, MIN_VAL};
  localparam logic [WIDTH:0] MAX_X     = {1'b0, MAX_VAL};
  localparam logic [WIDTH:0] RANGE_X   = MAX_X - MIN_X + ONE_X;
  localparam logic [WIDTH:0] UNDER_LIM = MIN_X + STEP;
  localparam logic [WIDTH:0] DN_ADJ    = RANGE_X - STEP;

  logic [WIDTH-1:0] saida_reg, saida_next;
  logic             estouro_reg, estouro_next;
  logic             subfluxo_reg, subfluxo_next;

  logic [1:0] req;
  logic [1:0] req_eff;
  logic       up;
  logic       dn;

  assign req = {bus.decrecer, bus.acrescer};

  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    if (EDGE_MODE) begin : g_edge
      logic hist_reg;
      // History follows the raw request every cycle, regardless of enable/load/clear.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hist_reg <= 1'b0;
        end else begin
          hist_reg <= req[gi];
        end
      end
      assign req_eff[gi] = req[gi] & ~hist_reg;
    end else begin : g_level
      assign req_eff[gi] = req[gi];
    end
  end

  assign up = bus.enable & req_eff[0] & ~req_eff[1];
  assign dn = bus.enable & req_eff[1] & ~req_eff[0];

  logic [WIDTH:0] cur_x;
  logic [WIDTH:0] carga_x;
  logic [WIDTH:0] up_sum;

  assign cur_x   = {1'b0, saida_reg};
  assign carga_x = {1'b0, bus.valor_carga};
  assign up_sum  = cur_x + STEP;

  always_comb begin
    saida_next    = saida_reg;
    estouro_next  = 1'b0;
    subfluxo_next = 1'b0;
    if (bus.limpar) begin
      saida_next = RESET_VAL;
    end else if (bus.carregar) begin
      if ((carga_x + ONE_X) <= MIN_X) begin
        saida_next = MIN_VAL;
      end else if (carga_x > MAX_X) begin
        saida_next = MAX_VAL;
      end else begin
        saida_next = bus.valor_carga;
      end
    end else if (up) begin
      if (up_sum > MAX_X) begin
        estouro_next = 1'b1;
        saida_next   = SATURATE ? MAX_VAL : WIDTH'(up_sum - RANGE_X);
      end else begin
        saida_next = WIDTH'(up_sum);
      end
    end else if (dn) begin
      // Crossing below MIN_VAL is detected before subtracting, so nothing goes negative.
      if (cur_x < UNDER_LIM) begin
        subfluxo_next = 1'b1;
        saida_next    = SATURATE ? MIN_VAL : WIDTH'(cur_x + DN_ADJ);
      end else begin
        saida_next = WIDTH'(cur_x - STEP);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      saida_reg    <= RESET_VAL;
      estouro_reg  <= 1'b0;
      subfluxo_reg <= 1'b0;
    end else begin
      saida_reg    <= saida_next;
      estouro_reg  <= estouro_next;
      subfluxo_reg <= subfluxo_next;
    end
  end

  assign bus.saida     = saida_reg;
  assign bus.no_maximo = (saida_reg == MAX_VAL);
  assign bus.no_minimo = (saida_reg == MIN_VAL);
  assign bus.estouro   = estouro_reg;
  assign bus.subfluxo  = subfluxo_reg;

endmodule

// File: tb/tb_contador_param.sv
// Runs several contador_param configurations on shared stimulus and checks each
// against an integer-arithmetic model every cycle, plus hand-computed points.
module tb_contador_param;

  localparam int N = 5;
  localparam int P_RV   [N] = '{106, 15, 15, 106, 100};
  localparam int P_MIN  [N] = '{0,   10, 10, 0,   3};
  localparam int P_MAX  [N] = '{255, 20, 20, 255, 255};
  localparam int P_STEP [N] = '{1,   3,  3,  1,   7};
  localparam int P_SAT  [N] = '{0,   1,  0,  0,   0};
  localparam int P_EDGE [N] = '{0,   0,  0,  1,   0};

  logic       clk;
  logic       rst_n;
  logic       enable, acrescer, decrecer, carregar, limpar;
  logic [7:0] valor_carga;

  logic [7:0] saida_a [N];
  logic       nmax_a  [N];
  logic       nmin_a  [N];
  logic       ov_a    [N];
  logic       un_a    [N];

  int errors = 0;
  int checks = 0;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    contador_param_if #(.WIDTH(8)) bus_i ();
    assign bus_i.enable      = enable;
    assign bus_i.acrescer    = acrescer;
    assign bus_i.decrecer    = decrecer;
    assign bus_i.carregar    = carregar;
    assign bus_i.valor_carga = valor_carga;
    assign bus_i.limpar      = limpar;

    contador_param #(
      .WIDTH     (8),
      .RESET_VAL (8'(P_RV[gi])),
      .MIN_VAL   (8'(P_MIN[gi])),
      .MAX_VAL   (8'(P_MAX[gi])),
      .STEP      (9'(P_STEP[gi])),
      .SATURATE  (P_SAT[gi] != 0),
      .EDGE_MODE (P_EDGE[gi] != 0)
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_i)
    );

    assign saida_a[gi] = bus_i.saida;
    assign nmax_a[gi]  = bus_i.no_maximo;
    assign nmin_a[gi]  = bus_i.no_minimo;
    assign ov_a[gi]    = bus_i.estouro;
    assign un_a[gi]    = bus_i.subfluxo;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: plain signed integer arithmetic on the counting rules.
  int m_val [N];
  bit m_ov  [N];
  bit m_un  [N];
  bit m_ha, m_hd;
  bit model_live = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_val[i] <= P_RV[i];
        m_ov[i]  <= 1'b0;
        m_un[i]  <= 1'b0;
      end
      m_ha       <= 1'b0;
      m_hd       <= 1'b0;
      model_live <= 1'b1;
    end else begin
      for (int i = 0; i < N; i++) begin
        int  v, n;
        bit  ov, un, ra, rd, want_up, want_dn;
        v  = m_val[i];
        ov = 1'b0;
        un = 1'b0;
        ra = (P_EDGE[i] != 0) ? (acrescer && !m_ha) : acrescer;
        rd = (P_EDGE[i] != 0) ? (decrecer && !m_hd) : decrecer;
        want_up = enable && ra && !rd;
        want_dn = enable && rd && !ra;
        if (limpar) begin
          v = P_RV[i];
        end else if (carregar) begin
          v = int'(valor_carga);
          if (v < P_MIN[i]) v = P_MIN[i];
          if (v > P_MAX[i]) v = P_MAX[i];
        end else if (want_up) begin
          n = v + P_STEP[i];
          if (n > P_MAX[i]) begin
            ov = 1'b1;
            v  = (P_SAT[i] != 0) ? P_MAX[i] : n - (P_MAX[i] - P_MIN[i] + 1);
          end else begin
            v = n;
          end
        end else if (want_dn) begin
          n = v - P_STEP[i];
          if (n < P_MIN[i]) begin
            un = 1'b1;
            v  = (P_SAT[i] != 0) ? P_MIN[i] : n + (P_MAX[i] - P_MIN[i] + 1);
          end else begin
            v = n;
          end
        end
        m_val[i] <= v;
        m_ov[i]  <= ov;
        m_un[i]  <= un;
      end
      m_ha <= acrescer;
      m_hd <= decrecer;
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      for (int i = 0; i < N; i++) begin
        chk($sformatf("saida[%0d]", i), int'(saida_a[i]), m_val[i]);
        chk($sformatf("no_maximo[%0d]", i), int'(nmax_a[i]), int'(m_val[i] == P_MAX[i]));
        chk($sformatf("no_minimo[%0d]", i), int'(nmin_a[i]), int'(m_val[i] == P_MIN[i]));
        chk($sformatf("estouro[%0d]", i), int'(ov_a[i]), int'(m_ov[i]));
        chk($sformatf("subfluxo[%0d]", i), int'(un_a[i]), int'(m_un[i]));
      end
    end
  end

  task automatic step_n(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic load(input int v);
    carregar = 1'b1;
    valor_carga = 8'(v);
    step_n(1);
    carregar = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b1;
    acrescer = 1'b0;
    decrecer = 1'b0;
    carregar = 1'b0;
    limpar = 1'b0;
    valor_carga = 8'h00;
    step_n(2);
    rst_n = 1'b1;
    step_n(1);
    chk("reset_saida", int'(saida_a[0]), 'h6A);
    chk("reset_estouro", int'(ov_a[0]), 0);
    chk("reset_sat_saida", int'(saida_a[1]), 15);

    // Level counting, then both requests high holds.
    acrescer = 1'b1;
    step_n(1); chk("up1", int'(saida_a[0]), 'h6B);
    step_n(1); chk("up2", int'(saida_a[0]), 'h6C);
    step_n(1); chk("up3", int'(saida_a[0]), 'h6D);
    decrecer = 1'b1;
    step_n(2); chk("both_hold", int'(saida_a[0]), 'h6D);
    acrescer = 1'b0;
    decrecer = 1'b0;

    // Wrap at the full-width boundary.
    load('hFF);
    chk("load_ff", int'(saida_a[0]), 'hFF);
    acrescer = 1'b1;
    step_n(1);
    acrescer = 1'b0;
    chk("wrap_up_val", int'(saida_a[0]), 0);
    chk("wrap_up_ov", int'(ov_a[0]), 1);
    chk("wrap_up_nmin", int'(nmin_a[0]), 1);
    step_n(1);
    chk("ov_one_cycle", int'(ov_a[0]), 0);
    decrecer = 1'b1;
    step_n(1);
    decrecer = 1'b0;
    chk("wrap_dn_val", int'(saida_a[0]), 'hFF);
    chk("wrap_dn_un", int'(un_a[0]), 1);

    // Narrow range, step 3: saturating (inst 1) and wrapping (inst 2).
    load(19);
    chk("load19_sat", int'(saida_a[1]), 19);
    acrescer = 1'b1;
    step_n(1);
    chk("sat_up_val", int'(saida_a[1]), 20);
    chk("sat_up_ov", int'(ov_a[1]), 1);
    chk("sat_up_nmax", int'(nmax_a[1]), 1);
    chk("wrap3_up_val", int'(saida_a[2]), 11);
    chk("wrap3_up_ov", int'(ov_a[2]), 1);
    step_n(1);
    acrescer = 1'b0;
    chk("sat_again_val", int'(saida_a[1]), 20);
    chk("sat_again_ov", int'(ov_a[1]), 1);
    load(11);
    decrecer = 1'b1;
    step_n(1);
    decrecer = 1'b0;
    chk("wrap3_dn_val", int'(saida_a[2]), 19);
    chk("wrap3_dn_un", int'(un_a[2]), 1);
    chk("sat_dn_val", int'(saida_a[1]), 10);
    load(30);
    chk("load30_clamp", int'(saida_a[1]), 20);
    load(2);
    chk("load2_clamp", int'(saida_a[1]), 10);

    // Edge mode (inst 3).
    limpar = 1'b1;
    step_n(1);
    limpar = 1'b0;
    chk("clear_edge", int'(saida_a[3]), 'h6A);
    acrescer = 1'b1;
    step_n(1); chk("edge_first", int'(saida_a[3]), 'h6B);
    step_n(4); chk("edge_held", int'(saida_a[3]), 'h6B);
    acrescer = 1'b0;
    step_n(1);
    acrescer = 1'b1;
    step_n(1); chk("edge_second", int'(saida_a[3]), 'h6C);
    acrescer = 1'b0;
    step_n(1);
    enable = 1'b0;
    acrescer = 1'b1;
    step_n(1); chk("edge_disabled", int'(saida_a[3]), 'h6C);
    acrescer = 1'b0;
    step_n(1);
    enable = 1'b1;
    acrescer = 1'b1;
    step_n(1); chk("edge_reenabled", int'(saida_a[3]), 'h6D);
    acrescer = 1'b0;

    // Asynchronous reset in the middle of counting.
    load('h6F);
    acrescer = 1'b1;
    step_n(1);
    chk("count_at_70", int'(saida_a[0]), 'h70);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_saida", int'(saida_a[0]), 'h6A);
    chk("async_rst_ov", int'(ov_a[0]), 0);
    chk("async_rst_sat", int'(saida_a[1]), 15);
    @(negedge clk);
    rst_n = 1'b1;
    acrescer = 1'b0;

    // Clear beats load beats count.
    limpar = 1'b1;
    carregar = 1'b1;
    acrescer = 1'b1;
    valor_carga = 8'h10;
    step_n(1);
    chk("prio_saida", int'(saida_a[0]), 'h6A);
    chk("prio_ov", int'(ov_a[0]), 0);
    limpar = 1'b0;
    carregar = 1'b0;
    acrescer = 1'b0;

    // Randomised traffic, with an occasional reset landing between edges.
    for (int c = 0; c < 2000; c++) begin
      limpar      = ($urandom_range(0, 31) == 0);
      carregar    = ($urandom_range(0, 15) == 0);
      enable      = ($urandom_range(0, 3) != 0);
      acrescer    = $urandom_range(0, 1) != 0;
      decrecer    = $urandom_range(0, 2) == 0;
      valor_carga = 8'($urandom_range(0, 255));
      if (c % 500 == 250) begin
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        @(negedge clk);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
